// File: rtl/seq_stream_pkg.sv
// rtl/seq_stream_pkg.sv - shared state encoding and constants for the stream serializer
package seq_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/stream_hold_buffer.sv
// rtl/stream_hold_buffer.sv - one-entry word buffer in front of the serializer shift register
module stream_hold_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             full
);

    // A load on the same edge as a drain wins, so the buffer ends up holding the new word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= '0;
            last <= 1'b0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            last <= load_last;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - parallel word to serial bit stream with inter-frame idle gap
module stream_serializer
    import seq_stream_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = IDLE_BIT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_end,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
    localparam bit              USE_GAP  = (GAP_CYCLES != 0);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [3:0]         gap_cnt;
    logic               cur_last;
    logic               started;

    logic [WIDTH-1:0]   hold_data;
    logic               hold_last;
    logic               hold_full;

    logic               accept;
    logic               word_done;
    logic               advance;
    logic               take_hold;
    logic               take_direct;

    // in_ready stays low until the first edge after reset release.
    assign in_ready = started && !hold_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        word_done   = (state == SHIFT) && (bit_cnt == LAST_BIT);
        advance     = (word_done && !(cur_last && USE_GAP))
                    || ((state == GAP) && (gap_cnt == GAP_LAST));
        take_hold   = advance && hold_full;
        take_direct = accept && ((state == IDLE) || (advance && !hold_full));
        shreg_next  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end

    stream_hold_buffer #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .load      (accept && !take_direct),
        .drain     (take_hold),
        .load_data (in_data),
        .load_last (in_last),
        .data      (hold_data),
        .last      (hold_last),
        .full      (hold_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            cur_last <= 1'b0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (take_hold) begin
                shreg    <= hold_data;
                cur_last <= hold_last;
                bit_cnt  <= '0;
                gap_cnt  <= '0;
                state    <= SHIFT;
            end else if (take_direct) begin
                shreg    <= in_data;
                cur_last <= in_last;
                bit_cnt  <= '0;
                gap_cnt  <= '0;
                state    <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (word_done) begin
                            bit_cnt <= '0;
                            gap_cnt <= '0;
                            state   <= advance ? IDLE : GAP;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            shreg   <= shreg_next;
                        end
                    end
                    GAP: begin
                        if (advance) begin
                            gap_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bit_valid = (state == SHIFT);
    assign bit_out   = bit_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
    assign frame_end = word_done && cur_last;
    assign busy      = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - randomized and directed bench against a schedule-based reference model
module tb_stream_serializer;

    localparam int W   = 8;
    localparam int GAP = 2;

    logic         clock;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         frame_end;
    logic         busy;

    logic [W-1:0] l_data;
    logic         l_valid;
    logic         l_last;
    logic         l_ready;
    logic         l_bit_out;
    logic         l_bit_valid;
    logic         l_frame_end;
    logic         l_busy;

    int n_checks = 0;
    int n_err    = 0;

    stream_serializer #(
        .WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP), .IDLE_BIT(1'b0)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .frame_end(frame_end), .busy(busy)
    );

    stream_serializer #(
        .WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP), .IDLE_BIT(1'b0)
    ) dut_lsb (
        .clock(clock), .reset(reset),
        .in_data(l_data), .in_valid(l_valid), .in_last(l_last), .in_ready(l_ready),
        .bit_out(l_bit_out), .bit_valid(l_bit_valid), .frame_end(l_frame_end), .busy(l_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted word gets an accept cycle and a start cycle.
    // A word starts at the later of (accept + 1) and the cycle the serial line frees up,
    // which is WIDTH bits after the previous start plus the gap if that word was last.
    int           wa[$];
    int           ws[$];
    logic [W-1:0] wd[$];
    bit           wl[$];
    int           free_at = 0;
    int           cyc     = 0;
    bit           started = 0;
    bit           took    = 0;

    logic [15:0]  cap;
    int           capn;
    int           fe_cnt;
    logic [7:0]   lcap;
    int           lcnt;

    always @(posedge clock) begin
        cyc++;
        if (reset) started = 1;
    end

    always @(negedge clock) begin
        logic e_bv, e_bo, e_fe, e_busy, e_rdy;
        int   e_end;
        int   s;
        e_bv = 0; e_bo = 0; e_fe = 0; e_busy = 0; e_rdy = 0;
        if (!reset) begin
            wa.delete(); ws.delete(); wd.delete(); wl.delete();
            free_at = 0;
            started = 0;
        end else begin
            e_rdy = started;
            foreach (wa[k]) begin
                e_end = ws[k] + W - 1;
                if (cyc >= ws[k] && cyc <= e_end) begin
                    e_bv = 1;
                    e_bo = wd[k][W-1-(cyc-ws[k])];
                    e_fe = wl[k] && (cyc == e_end);
                end
                if (cyc >= ws[k] && cyc <= e_end + (wl[k] ? GAP : 0)) e_busy = 1;
                if (wa[k] < cyc && cyc < ws[k]) begin
                    e_rdy  = 0;
                    e_busy = 1;
                end
            end
        end
        check("bit_valid", bit_valid, e_bv);
        check("bit_out", bit_out, e_bo);
        check("frame_end", frame_end, e_fe);
        check("busy", busy, e_busy);
        check("in_ready", in_ready, e_rdy);
        if (bit_valid) begin
            cap  = {cap[14:0], bit_out};
            capn++;
        end
        if (frame_end) fe_cnt++;
        if (l_bit_valid) begin
            lcap = {lcap[6:0], l_bit_out};
            lcnt++;
        end
        if (reset && in_valid && e_rdy) begin
            s = (cyc + 1 > free_at) ? cyc + 1 : free_at;
            wa.push_back(cyc);
            ws.push_back(s);
            wd.push_back(in_data);
            wl.push_back(in_last);
            free_at = s + W + (in_last ? GAP : 0);
            took = 1;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        took     = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!took && n < 100);
        if (!took) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        repeat (n) begin
            @(posedge clock);
            #1;
            in_data = W'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        l_valid = 1'b0; l_data = '0; l_last = 1'b0;
        cap = '0; capn = 0; fe_cnt = 0; lcap = '0; lcnt = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check("ready_before_edge", in_ready, 1'b0);
        @(posedge clock); #1;
        check("ready_after_release", in_ready, 1'b1);

        cap = '0; capn = 0;
        send(8'hA5, 1'b0);
        idle(12);
        check("a5_bits", cap[7:0], 8'hA5);
        check("a5_count", capn, 8);
        check("a5_idle_busy", busy, 1'b0);

        cap = '0; capn = 0;
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        idle(20);
        check("ff00_bits", cap, 16'hFF00);
        check("ff00_count", capn, 16);

        cap = '0; capn = 0; fe_cnt = 0;
        send(8'h0F, 1'b1);
        send(8'hF0, 1'b0);
        idle(20);
        check("frame_bits", cap, 16'h0FF0);
        check("frame_end_pulses", fe_cnt, 1);

        send(8'hC3, 1'b0);
        send(8'h5A, 1'b0);
        idle(2);
        reset = 1'b0;
        #1;
        check("rst_async_valid", bit_valid, 1'b0);
        check("rst_async_ready", in_ready, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        cap = '0; capn = 0;
        send(8'h81, 1'b0);
        idle(16);
        check("post_rst_bits", cap[7:0], 8'h81);
        check("post_rst_count", capn, 8);

        lcap = '0; lcnt = 0;
        check("lsb_ready", l_ready, 1'b1);
        l_data = 8'h01; l_last = 1'b0; l_valid = 1'b1;
        @(posedge clock); #1;
        l_valid = 1'b0; l_data = 8'hFF;
        idle(12);
        check("lsb_bits", lcap, 8'h80);
        check("lsb_count", lcnt, 8);

        for (int i = 0; i < 60; i++) begin
            int g;
            g = $urandom_range(0, 3);
            if (g != 0) idle(g);
            send(W'($urandom), ($urandom_range(0, 3) == 0));
        end
        idle(40);
        check("final_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
